// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU control codes, ALUOp and funct encodings
package cpu_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RA_W = 3;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [1:0] OP_MEM = 2'b00;
  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_R = 2'b10;
  localparam logic [1:0] OP_SLTI = 2'b11;
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_SLT = 4'b0010;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: single-operand forwarding select with EX/MEM priority and r0 forced to zero
module fwd_mux #(
  parameter int DATA_W = 16,
  parameter int RA_W = 3
) (
  input  logic [RA_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_reg_write,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data
);
  always_comb
    data = reg_addr == '0 ? '0 :
           (exm_reg_write && exm_rd == reg_addr) ? exm_result :
           (wb_reg_write && wb_rd == reg_addr) ? wb_data : reg_data;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register, operand forwarding, ALU-control decode and load-use detection
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RA_W = DEF_RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_op,
  input  logic [3:0]        id_funct,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] source1,
  output logic [DATA_W-1:0] source2,
  output logic [3:0]        ALU_CTRL,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              illegal,
  output logic              load_use_stall
);
  logic              v, alu_src, reg_write, mem_read, mem_write, funct_ok;
  logic [RA_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] rs_data, rt_data, imm, fwd_a, fwd_b;
  logic [1:0]        alu_op;
  logic [3:0]        funct, r_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      rs <= '0;
      rt <= '0;
      rd <= '0;
      rs_data <= '0;
      rt_data <= '0;
      imm <= '0;
      alu_src <= 1'b0;
      alu_op <= OP_MEM;
      funct <= FN_ADD;
      reg_write <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
      reg_write <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else if (!stall) begin
      v <= id_valid;
      rs <= id_rs;
      rt <= id_rt;
      rd <= id_rd;
      rs_data <= id_rs_data;
      rt_data <= id_rt_data;
      imm <= id_imm;
      alu_src <= id_alu_src;
      alu_op <= id_alu_op;
      funct <= id_funct;
      reg_write <= id_reg_write;
      mem_read <= id_mem_read;
      mem_write <= id_mem_write;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
    .reg_addr(rs), .reg_data(rs_data),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
    .reg_addr(rt), .reg_data(rt_data),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(fwd_b)
  );

  always_comb begin
    funct_ok = funct == FN_ADD || funct == FN_SUB || funct == FN_SLT;
    r_ctrl = funct == FN_SUB ? ALU_SUB : funct == FN_SLT ? ALU_SLT : ALU_ADD;
    ALU_CTRL = alu_op == OP_BEQ ? ALU_SUB : alu_op == OP_SLTI ? ALU_SLT :
               alu_op == OP_R ? r_ctrl : ALU_ADD;
    illegal = v && alu_op == OP_R && !funct_ok;
    source1 = fwd_a;
    source2 = alu_src ? imm : fwd_b;
    ex_store_data = fwd_b;
    ex_valid = v;
    ex_reg_write = v && reg_write;
    ex_mem_read = v && mem_read;
    ex_mem_write = v && mem_write;
    ex_rd = rd;
    load_use_stall = v && mem_read && rd != '0 && id_valid &&
                     (id_rs == rd || (id_rt == rd && !id_alu_src));
  end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: vector table, directed corner sequences and random stimulus against a reference model
module tb_ex_operand_stage;
  logic clk = 1'b0;
  logic rst, id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [2:0] id_rs, id_rt, id_rd, exm_rd, wb_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm, exm_result, wb_data;
  logic [1:0] id_alu_op;
  logic [3:0] id_funct;
  logic stall, flush, exm_reg_write, wb_reg_write;
  logic [15:0] source1, source2, ex_store_data;
  logic [3:0] ALU_CTRL;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, illegal, load_use_stall;
  logic [2:0] ex_rd;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic v, dk, src, rw, mr, mw;
    logic [2:0] rs, rt, rd;
    logic [15:0] rsd, rtd, imm;
    logic [1:0] op;
    logic [3:0] fn;
  } model_t;
  model_t m;

  typedef struct {
    logic [1:0] op;
    logic [3:0] fn;
    logic [3:0] ctrl;
    logic ill;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .source1(source1), .source2(source2), .ALU_CTRL(ALU_CTRL), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .illegal(illegal),
    .load_use_stall(load_use_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                        input logic [15:0] imm, input logic src, input logic [1:0] op,
                        input logic [3:0] fn, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_src = src; id_alu_op = op; id_funct = fn;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic fwd_off();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic tick();
    if (rst) begin
      m = '{default: '0};
    end else if (flush) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.dk = 1;
    end else if (!stall) begin
      m.v = id_valid; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm; m.src = id_alu_src;
      m.op = id_alu_op; m.fn = id_funct; m.rw = id_reg_write; m.mr = id_mem_read;
      m.mw = id_mem_write; m.dk = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_fwd(input logic [2:0] r, input logic [15:0] d);
    if (r == 0) return 16'h0;
    if (exm_reg_write && exm_rd == r) return exm_result;
    if (wb_reg_write && wb_rd == r) return wb_data;
    return d;
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [3:0] fn);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b11: return 4'b0111;
      default: return fn == 4'd1 ? 4'b0110 : fn == 4'd2 ? 4'b0111 : 4'b0010;
    endcase
  endfunction

  task automatic check_model();
    logic [15:0] a, b;
    #1;
    a = ref_fwd(m.rs, m.rsd);
    b = ref_fwd(m.rt, m.rtd);
    chk("ex_valid", ex_valid, m.v);
    chk("ex_reg_write", ex_reg_write, m.v & m.rw);
    chk("ex_mem_read", ex_mem_read, m.v & m.mr);
    chk("ex_mem_write", ex_mem_write, m.v & m.mw);
    chk("illegal", illegal, m.v && m.op == 2'b10 && m.fn > 4'd2);
    chk("load_use_stall", load_use_stall, m.v && m.mr && m.rd != 0 && id_valid &&
        (id_rs == m.rd || (id_rt == m.rd && !id_alu_src)));
    if (!m.dk) begin
      chk("source1", source1, a);
      chk("source2", source2, m.src ? m.imm : b);
      chk("ex_store_data", ex_store_data, b);
      chk("ex_rd", ex_rd, m.rd);
      chk("ALU_CTRL", ALU_CTRL, ref_ctrl(m.op, m.fn));
    end
  endtask

  initial begin
    logic [15:0] s1, s2;
    vecs[0] = '{2'b10, 4'b0000, 4'b0010, 1'b0};
    vecs[1] = '{2'b10, 4'b0001, 4'b0110, 1'b0};
    vecs[2] = '{2'b10, 4'b0010, 4'b0111, 1'b0};
    vecs[3] = '{2'b10, 4'b0101, 4'b0010, 1'b1};
    vecs[4] = '{2'b01, 4'b0101, 4'b0110, 1'b0};
    vecs[5] = '{2'b11, 4'b0000, 4'b0111, 1'b0};
    vecs[6] = '{2'b00, 4'b1111, 4'b0010, 1'b0};
    vecs[7] = '{2'b10, 4'b1111, 4'b0010, 1'b1};
    m = '{default: '0};
    stall = 0; flush = 0; rst = 1;
    fwd_off();
    set_id(1, 3'd1, 3'd2, 3'd3, 16'h1111, 16'h2222, 16'h3333, 0, 2'b01, 4'd0, 1, 0, 0);
    tick();
    tick();
    chk("rst ex_valid", ex_valid, 0);
    chk("rst ALU_CTRL", ALU_CTRL, 4'b0010);
    chk("rst source1", source1, 0);
    chk("rst source2", source2, 0);
    check_model();
    rst = 0;
    tick();
    chk("first ex_valid", ex_valid, 1);
    chk("first source1", source1, 16'h1111);
    chk("first ALU_CTRL", ALU_CTRL, 4'b0110);
    check_model();

    for (int i = 0; i < 8; i++) begin
      set_id(1, 3'd1, 3'd2, 3'd5, 16'h0A0A, 16'h0B0B, 16'h0, 0, vecs[i].op, vecs[i].fn, 1, 0, 0);
      tick();
      chk("vec ALU_CTRL", ALU_CTRL, vecs[i].ctrl);
      chk("vec illegal", illegal, vecs[i].ill);
      check_model();
    end

    set_id(1, 3'd3, 3'd1, 3'd5, 16'h1111, 16'h0, 16'h0, 0, 2'b10, 4'd0, 1, 0, 0);
    tick();
    exm_reg_write = 1; exm_rd = 3; exm_result = 16'h1234;
    wb_reg_write = 1; wb_rd = 3; wb_data = 16'h5678;
    #1 chk("fwd exm prio", source1, 16'h1234);
    exm_reg_write = 0;
    #1 chk("fwd wb", source1, 16'h5678);
    set_id(1, 3'd0, 3'd1, 3'd5, 16'hBEEF, 16'h0, 16'h0, 0, 2'b10, 4'd0, 1, 0, 0);
    tick();
    exm_reg_write = 1; exm_rd = 0; wb_rd = 0;
    #1 chk("fwd r0", source1, 16'h0);
    check_model();

    fwd_off();
    set_id(1, 3'd1, 3'd2, 3'd5, 16'h0, 16'h0, 16'hFFF0, 1, 2'b00, 4'd0, 1, 0, 0);
    tick();
    wb_reg_write = 1; wb_rd = 2; wb_data = 16'h00AA;
    #1 chk("imm source2", source2, 16'hFFF0);
    chk("store fwd", ex_store_data, 16'h00AA);
    check_model();

    fwd_off();
    set_id(1, 3'd1, 3'd0, 3'd4, 16'h0, 16'h0, 16'h8, 1, 2'b00, 4'd0, 1, 1, 0);
    tick();
    set_id(1, 3'd4, 3'd2, 3'd6, 16'h0, 16'h0, 16'h0, 0, 2'b10, 4'd0, 1, 0, 0);
    #1 chk("load-use rs", load_use_stall, 1);
    check_model();
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    chk("bubble ex_valid", ex_valid, 0);
    chk("bubble ex_reg_write", ex_reg_write, 0);
    check_model();
    set_id(1, 3'd1, 3'd0, 3'd4, 16'h0, 16'h0, 16'h8, 1, 2'b00, 4'd0, 1, 1, 0);
    tick();
    set_id(1, 3'd1, 3'd4, 3'd6, 16'h0, 16'h0, 16'h0, 1, 2'b00, 4'd0, 1, 0, 0);
    #1 chk("load-use imm rt", load_use_stall, 0);
    check_model();

    set_id(1, 3'd1, 3'd2, 3'd3, 16'hAAAA, 16'h5555, 16'h0, 0, 2'b10, 4'd1, 1, 0, 0);
    tick();
    s1 = source1; s2 = source2;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 3'd6, 3'd7, 3'd1, 16'($urandom), 16'($urandom), 16'($urandom), 1, 2'b11, 4'd9, 0, 1, 1);
      tick();
      chk("stall source1", source1, 16'hAAAA);
      chk("stall source2", source2, 16'h5555);
      chk("stall ALU_CTRL", ALU_CTRL, 4'b0110);
      check_model();
    end
    flush = 1;
    tick();
    chk("stall+flush ex_valid", ex_valid, 0);
    check_model();
    stall = 0; flush = 0;
    tick();
    rst = 1; flush = 1;
    tick();
    rst = 0; flush = 0;
    chk("rst+flush ex_valid", ex_valid, 0);
    chk("rst+flush ALU_CTRL", ALU_CTRL, 4'b0010);
    chk("rst+flush source1", source1, 0);
    check_model();

    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 40) == 0;
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 7) == 0;
      set_id(1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), 4'($urandom_range(0, 4)),
             1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      exm_reg_write = 1'($urandom); exm_rd = 3'($urandom); exm_result = 16'($urandom);
      wb_reg_write = 1'($urandom); wb_rd = 3'($urandom); wb_data = 16'($urandom);
      id_rs = 3'($urandom); id_rt = 3'($urandom); id_alu_src = 1'($urandom);
      check_model();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
